// File: rtl/tswitch_cfg_arbiter_if.sv
// Requester handshake plus T-switch ctrl_reg bus for tswitch_cfg_arbiter.
// The arbiter takes the slave modport; requesters and the tswitch side take master.
interface tswitch_cfg_arbiter_if;
  logic [1:0]  req_valid;
  logic [3:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_err;
  logic [7:0]  ctrl_reg_addr;
  logic [7:0]  ctrl_reg_wdata;
  logic        ctrl_reg_rd;
  logic        ctrl_reg_en;
  logic [7:0]  ctrl_reg_rdata;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, ctrl_reg_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           ctrl_reg_addr, ctrl_reg_wdata, ctrl_reg_rd, ctrl_reg_en
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, ctrl_reg_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           ctrl_reg_addr, ctrl_reg_wdata, ctrl_reg_rd, ctrl_reg_en
  );
endinterface

// File: rtl/tswitch_cfg_arbiter.sv
// Round-robin arbiter sharing the T-switch ctrl_reg port between two requesters,
// with optional deferral of write strobes to the 8 kHz frame boundary.
module tswitch_cfg_arbiter #(
  parameter int unsigned RD_LAT         = 2,
  parameter bit          ALIGN_TO_FRAME = 1'b1
) (
  input  logic                        clk_system,
  input  logic                        rst_n,
  input  logic                        frame_sync,
  tswitch_cfg_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_RD  = 2'b01,
    OP_WV  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    WR,
    RD,
    RD_WAIT,
    RESP
  } state_e;

  localparam logic [2:0] RD_LAT_CNT = 3'(RD_LAT);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rr_last_q;
  logic       gnt_q;
  op_e        op_q;
  logic [7:0] addr_q, wdata_q;
  logic [7:0] rdata_q;
  logic       err_q;
  logic [7:0] ctrl_addr_q, ctrl_wdata_q;

  logic       gnt_d;
  op_e        req_op_g;
  logic [7:0] req_addr_g, req_wdata_g;
  logic       accept, sample, strobe;

  // With both requesting, the one not served last wins; otherwise whoever asks.
  assign gnt_d       = (bus.req_valid == 2'b11) ? ~rr_last_q : bus.req_valid[1];
  assign req_op_g    = op_e'(gnt_d ? bus.req_op[3:2] : bus.req_op[1:0]);
  assign req_addr_g  = gnt_d ? bus.req_addr[15:8]  : bus.req_addr[7:0];
  assign req_wdata_g = gnt_d ? bus.req_wdata[15:8] : bus.req_wdata[7:0];

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    sample  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          accept = 1'b1;
          case (req_op_g)
            OP_WR, OP_WV: state_d = ALIGN_TO_FRAME ? WAIT_FRAME : WR;
            OP_RD:        state_d = RD;
            default:      state_d = RESP;
          endcase
        end
      end
      // A pulse in the acceptance cycle is seen while still in IDLE, so it is skipped.
      WAIT_FRAME: if (frame_sync) state_d = WR;
      WR:         state_d = (op_q == OP_WV) ? RD : RESP;
      RD: begin
        cnt_d   = RD_LAT_CNT;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          sample  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    strobe = (state_d == WR) || (state_d == RD);
  end

  // NOTE: reset is synchronous to clk_system, and all state uses non-blocking
  // assignments so every register samples pre-edge values.
  always_ff @(posedge clk_system) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_system) begin
    if (!rst_n) begin
      rr_last_q    <= 1'b1;
      gnt_q        <= 1'b0;
      op_q         <= OP_WR;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      rdata_q      <= 8'h00;
      err_q        <= 1'b0;
      ctrl_addr_q  <= 8'h00;
      ctrl_wdata_q <= 8'h00;
    end else begin
      if (accept) begin
        rr_last_q <= gnt_d;
        gnt_q     <= gnt_d;
        op_q      <= req_op_g;
        addr_q    <= req_addr_g;
        wdata_q   <= req_wdata_g;
        rdata_q   <= 8'h00;
        err_q     <= (req_op_g == OP_RSV);
      end
      if (sample) begin
        rdata_q <= bus.ctrl_reg_rdata;
        err_q   <= (op_q == OP_WV) && (bus.ctrl_reg_rdata != wdata_q);
      end
      // Bus address/data only move on a strobe so they hold between accesses.
      if (strobe) begin
        ctrl_addr_q  <= accept ? req_addr_g  : addr_q;
        ctrl_wdata_q <= accept ? req_wdata_g : wdata_q;
      end
    end
  end

  assign bus.req_ready      = accept ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
  assign bus.resp_valid     = (state_q == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.resp_rdata     = rdata_q;
  assign bus.resp_err       = (state_q == RESP) && err_q;
  assign bus.ctrl_reg_en    = (state_q == WR) || (state_q == RD);
  assign bus.ctrl_reg_rd    = (state_q == RD);
  assign bus.ctrl_reg_addr  = ctrl_addr_q;
  assign bus.ctrl_reg_wdata = ctrl_wdata_q;

endmodule

// File: tb/tb_tswitch_cfg_arbiter.sv
// Directed bench for tswitch_cfg_arbiter: one unaligned and one frame-aligned
// instance, with bus strobes and responses checked against a timed scoreboard.
module tb_tswitch_cfg_arbiter;

  localparam int RD_LAT = 2;
  localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_WV = 2'b10, OP_RSV = 2'b11;

  typedef struct {
    int         d;
    int         cyc;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
  } bus_t;

  typedef struct {
    int         d;
    int         id;
    int         cyc;
    logic       err;
    logic       chk;
    logic [7:0] rdata;
  } resp_t;

  logic clk_system = 1'b0;
  logic rst_n      = 1'b0;
  logic frame_sync = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bus_t  bus_q[$];
  resp_t resp_q[$];

  logic [1:0]  req_valid [2];
  logic [3:0]  req_op    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic [7:0]  model_val [2];
  int          rd_due    [2];

  logic [1:0] rdy_w  [2];
  logic [1:0] rv_w   [2];
  logic [7:0] rdat_w [2];
  logic       err_w  [2];
  logic       en_w   [2];
  logic       rd_w   [2];
  logic [7:0] addr_w [2];
  logic [7:0] wdat_w [2];

  tswitch_cfg_arbiter_if bus0 ();
  tswitch_cfg_arbiter_if bus1 ();

  tswitch_cfg_arbiter #(.RD_LAT(RD_LAT), .ALIGN_TO_FRAME(1'b0)) u_dut0 (
    .clk_system (clk_system),
    .rst_n      (rst_n),
    .frame_sync (frame_sync),
    .bus        (bus0)
  );

  tswitch_cfg_arbiter #(.RD_LAT(RD_LAT), .ALIGN_TO_FRAME(1'b1)) u_dut1 (
    .clk_system (clk_system),
    .rst_n      (rst_n),
    .frame_sync (frame_sync),
    .bus        (bus1)
  );

  assign bus0.req_valid = req_valid[0];
  assign bus0.req_op    = req_op[0];
  assign bus0.req_addr  = req_addr[0];
  assign bus0.req_wdata = req_wdata[0];
  assign bus1.req_valid = req_valid[1];
  assign bus1.req_op    = req_op[1];
  assign bus1.req_addr  = req_addr[1];
  assign bus1.req_wdata = req_wdata[1];

  // Tswitch model: read data is only valid exactly RD_LAT cycles after the strobe.
  assign bus0.ctrl_reg_rdata = (cyc == rd_due[0]) ? model_val[0] : 8'hEE;
  assign bus1.ctrl_reg_rdata = (cyc == rd_due[1]) ? model_val[1] : 8'hEE;

  assign rdy_w[0]  = bus0.req_ready;      assign rdy_w[1]  = bus1.req_ready;
  assign rv_w[0]   = bus0.resp_valid;     assign rv_w[1]   = bus1.resp_valid;
  assign rdat_w[0] = bus0.resp_rdata;     assign rdat_w[1] = bus1.resp_rdata;
  assign err_w[0]  = bus0.resp_err;       assign err_w[1]  = bus1.resp_err;
  assign en_w[0]   = bus0.ctrl_reg_en;    assign en_w[1]   = bus1.ctrl_reg_en;
  assign rd_w[0]   = bus0.ctrl_reg_rd;    assign rd_w[1]   = bus1.ctrl_reg_rd;
  assign addr_w[0] = bus0.ctrl_reg_addr;  assign addr_w[1] = bus1.ctrl_reg_addr;
  assign wdat_w[0] = bus0.ctrl_reg_wdata; assign wdat_w[1] = bus1.ctrl_reg_wdata;

  always #5 clk_system = ~clk_system;

  always @(posedge clk_system) begin
    if (bus0.ctrl_reg_en && bus0.ctrl_reg_rd) rd_due[0] <= cyc + RD_LAT;
    if (bus1.ctrl_reg_en && bus1.ctrl_reg_rd) rd_due[1] <= cyc + RD_LAT;
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_bus(input int d, input int c, input logic rd,
                                   input logic [7:0] addr, input logic [7:0] wdata);
    bus_t b;
    b.d = d; b.cyc = c; b.rd = rd; b.addr = addr; b.wdata = wdata;
    bus_q.push_back(b);
  endfunction

  function automatic void push_resp(input int d, input int id, input int c, input logic err,
                                    input logic chk, input logic [7:0] rdata);
    resp_t r;
    r.d = d; r.id = id; r.cyc = c; r.err = err; r.chk = chk; r.rdata = rdata;
    resp_q.push_back(r);
  endfunction

  // Scoreboard monitor: every strobe and every response must match the queue head.
  always @(negedge clk_system) begin
    bus_t  b;
    resp_t r;
    #2;
    for (int d = 0; d < 2; d++) begin
      if (en_w[d]) begin
        check("bus_strobe_expected", 32'(bus_q.size() != 0), 1);
        if (bus_q.size() != 0) begin
          b = bus_q.pop_front();
          check("bus_dut", d, b.d);
          check("bus_cycle", cyc, b.cyc);
          check("bus_cmd", {rd_w[d], addr_w[d], b.rd ? 8'h00 : wdat_w[d]},
                           {b.rd, b.addr, b.rd ? 8'h00 : b.wdata});
        end
      end
      if (rv_w[d] != 2'b00) begin
        check("resp_onehot", $countones(rv_w[d]), 1);
        check("resp_expected", 32'(resp_q.size() != 0), 1);
        if (resp_q.size() != 0) begin
          r = resp_q.pop_front();
          check("resp_dut", d, r.d);
          check("resp_id", rv_w[d], 2'b01 << r.id);
          check("resp_cycle", cyc, r.cyc);
          check("resp_err", err_w[d], r.err);
          if (r.chk) check("resp_rdata", rdat_w[d], r.rdata);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with valid dropped.
  task automatic issue(input int d, input int id, input logic [1:0] op, input logic [7:0] addr,
                       input logic [7:0] wdata, output int acc);
    req_op[d][2*id +: 2]    = op;
    req_addr[d][8*id +: 8]  = addr;
    req_wdata[d][8*id +: 8] = wdata;
    req_valid[d][id]        = 1'b1;
    acc = -1;
    for (int n = 0; n < 40 && acc < 0; n++) begin
      #1;
      if (rdy_w[d] != 2'b00) begin
        acc = cyc;
        check("req_ready", rdy_w[d], 2'b01 << id);
      end
      @(negedge clk_system);
    end
    req_valid[d][id] = 1'b0;
    check("accept_in_time", 32'(acc >= 0), 1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 60 && (bus_q.size() != 0 || resp_q.size() != 0); n++)
      @(negedge clk_system);
    repeat (2) @(negedge clk_system);
    #3;
    check("drain_bus", bus_q.size(), 0);
    check("drain_resp", resp_q.size(), 0);
    @(negedge clk_system);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_system);
    #1;
    for (int d = 0; d < 2; d++)
      check("reset_outputs", {en_w[d], rd_w[d], rv_w[d], rdy_w[d], err_w[d], rdat_w[d],
                              addr_w[d], wdat_w[d]}, 0);
    @(negedge clk_system);
    rst_n = 1'b1;
    @(negedge clk_system);
  endtask

  initial begin
    int acc;
    int grants;
    int pend;
    int g;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0; req_op[d] = '0; req_addr[d] = '0; req_wdata[d] = '0;
      model_val[d] = 8'h00; rd_due[d] = -1;
    end

    // Power-on reset
    do_reset();

    // Unaligned write: ready@0, strobe@1, resp@2
    issue(0, 0, OP_WR, 8'h01, 8'h12, acc);
    push_bus(0, acc + 1, 1'b0, 8'h01, 8'h12);
    push_resp(0, 0, acc + 2, 1'b0, 1'b0, 8'h00);
    wait_drain();

    // Both requesting continuously: grants 0,1,0,1 from a fresh pointer
    do_reset();
    req_op[0] = {OP_WR, OP_WR};
    req_addr[0] = 16'h5040;
    req_wdata[0] = 16'hB0A0;
    req_valid[0] = 2'b11;
    grants = 0;
    pend = -1;
    for (int n = 0; n < 100 && grants < 4; n++) begin
      if (pend >= 0) begin
        req_addr[0][8*pend +: 8]  = req_addr[0][8*pend +: 8] + 8'h01;
        req_wdata[0][8*pend +: 8] = req_wdata[0][8*pend +: 8] + 8'h01;
        pend = -1;
      end
      #1;
      if (rdy_w[0] != 2'b00) begin
        check("pair_ready_onehot", $countones(rdy_w[0]), 1);
        g = rdy_w[0][1] ? 1 : 0;
        check("pair_grant_order", g, grants % 2);
        push_bus(0, cyc + 1, 1'b0, req_addr[0][8*g +: 8], req_wdata[0][8*g +: 8]);
        push_resp(0, g, cyc + 2, 1'b0, 1'b0, 8'h00);
        grants++;
        pend = g;
      end
      @(negedge clk_system);
    end
    req_valid[0] = 2'b00;
    check("pair_grant_count", grants, 4);
    wait_drain();

    // Read: strobe@1, resp@RD_LAT+2 with model data
    model_val[0] = 8'h08;
    issue(0, 0, OP_RD, 8'h13, 8'h00, acc);
    push_bus(0, acc + 1, 1'b1, 8'h13, 8'h00);
    push_resp(0, 0, acc + 4, 1'b0, 1'b1, 8'h08);
    wait_drain();

    // Verify with readback mismatch
    model_val[0] = 8'h55;
    issue(0, 1, OP_WV, 8'h02, 8'h13, acc);
    push_bus(0, acc + 1, 1'b0, 8'h02, 8'h13);
    push_bus(0, acc + 2, 1'b1, 8'h02, 8'h00);
    push_resp(0, 1, acc + 5, 1'b1, 1'b1, 8'h55);
    wait_drain();

    // Verify with matching readback
    model_val[0] = 8'h13;
    issue(0, 1, OP_WV, 8'h02, 8'h13, acc);
    push_bus(0, acc + 1, 1'b0, 8'h02, 8'h13);
    push_bus(0, acc + 2, 1'b1, 8'h02, 8'h00);
    push_resp(0, 1, acc + 5, 1'b0, 1'b1, 8'h13);
    wait_drain();

    // Reserved op: error response next cycle and no bus strobe
    issue(0, 0, OP_RSV, 8'h33, 8'h44, acc);
    push_resp(0, 0, acc + 1, 1'b1, 1'b0, 8'h00);
    wait_drain();

    // Frame-aligned write: pulse at acceptance ignored, next pulse 5 cycles later
    frame_sync = 1'b1;
    issue(1, 1, OP_WR, 8'h12, 8'h07, acc);
    frame_sync = 1'b0;
    push_bus(1, acc + 6, 1'b0, 8'h12, 8'h07);
    push_resp(1, 1, acc + 7, 1'b0, 1'b0, 8'h00);
    repeat (4) @(negedge clk_system);
    frame_sync = 1'b1;
    @(negedge clk_system);
    frame_sync = 1'b0;
    wait_drain();

    // Reset during RD_WAIT abandons the read; a fresh read then completes
    model_val[0] = 8'h77;
    issue(0, 0, OP_RD, 8'h21, 8'h00, acc);
    push_bus(0, acc + 1, 1'b1, 8'h21, 8'h00);
    @(negedge clk_system);
    rst_n = 1'b0;
    @(negedge clk_system);
    #1;
    check("midreset_outputs", {en_w[0], rd_w[0], rv_w[0], err_w[0], rdat_w[0], addr_w[0],
                               wdat_w[0]}, 0);
    @(negedge clk_system);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_system);
    model_val[0] = 8'h5A;
    issue(0, 1, OP_RD, 8'h2C, 8'h00, acc);
    push_bus(0, acc + 1, 1'b1, 8'h2C, 8'h00);
    push_resp(0, 1, acc + 4, 1'b0, 1'b1, 8'h5A);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
